// File: rtl/comma_aligner_if.sv
// Serial-side bundle for the comma aligner: bit stream plus enable in, aligned symbols out.
interface comma_aligner_if;
  logic       enb;
  logic       serialIn;
  logic [9:0] dataOut;
  logic       symValid;
  logic       esK285;
  logic       rxValid;
  logic [3:0] offsetCnt;

  modport master (
    output enb, serialIn,
    input  dataOut, symValid, esK285, rxValid, offsetCnt
  );

  modport slave (
    input  enb, serialIn,
    output dataOut, symValid, esK285, rxValid, offsetCnt
  );
endinterface

// File: rtl/comma_aligner.sv
// K28.5 comma aligner: acquires 10-bit symbol lock on a serial stream and emits
// aligned symbols with a one-cycle strobe, dropping lock on persistent misalignment.
module comma_aligner #(
  parameter int LOCK_COUNT = 2,
  parameter int LOSS_COUNT = 4
) (
  input  logic            clk,
  input  logic            rst,
  comma_aligner_if.slave  bus
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  // Both running disparities are accepted; no disparity state is tracked.
  function automatic logic isK285(input logic [9:0] s);
    return (s == 10'b0011111010) || (s == 10'b1100000101);
  endfunction

  state_t     state;
  logic [9:0] sr;
  logic [9:0] nxt;
  logic [3:0] ph;
  logic [3:0] cnt;
  logic [3:0] err;
  logic [9:0] dataReg;
  logic       symReg;
  logic       kReg;
  logic       rxReg;
  logic       isComma;
  logic       onBoundary;

  assign nxt        = {sr[8:0], bus.serialIn};
  assign isComma    = isK285(nxt);
  assign onBoundary = (ph == 4'd9);

  assign bus.dataOut   = dataReg;
  assign bus.symValid  = symReg;
  assign bus.esK285    = kReg;
  assign bus.rxValid   = rxReg;
  assign bus.offsetCnt = ph;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= UNLOCKED;
      sr      <= '0;
      ph      <= '0;
      cnt     <= '0;
      err     <= '0;
      dataReg <= '0;
      symReg  <= 1'b0;
      kReg    <= 1'b0;
      rxReg   <= 1'b0;
    end else begin
      // Strobes last exactly one clock, and disabled cycles never carry one.
      symReg <= 1'b0;
      kReg   <= 1'b0;
      if (bus.enb) begin
        sr <= nxt;
        ph <= onBoundary ? 4'd0 : ph + 4'd1;
        unique case (state)
          UNLOCKED: begin
            if (isComma) begin
              ph  <= 4'd0;
              cnt <= 4'd1;
              err <= 4'd0;
              if (LOCK_N == 4'd1) begin
                state   <= LOCKED;
                rxReg   <= 1'b1;
                dataReg <= nxt;
                symReg  <= 1'b1;
                kReg    <= 1'b1;
              end else begin
                state <= CHECK;
              end
            end
          end
          CHECK: begin
            if (isComma) begin
              if (onBoundary) begin
                cnt <= cnt + 4'd1;
                if (cnt + 4'd1 == LOCK_N) begin
                  // The comma that completes lock is delivered as a symbol.
                  state   <= LOCKED;
                  rxReg   <= 1'b1;
                  err     <= 4'd0;
                  dataReg <= nxt;
                  symReg  <= 1'b1;
                  kReg    <= 1'b1;
                end
              end else begin
                ph  <= 4'd0;
                cnt <= 4'd1;
              end
            end
          end
          LOCKED: begin
            if (onBoundary) begin
              dataReg <= nxt;
              symReg  <= 1'b1;
              kReg    <= isComma;
              if (isComma) err <= 4'd0;
            end else if (isComma) begin
              // Misplaced commas are counted but never shift the locked boundary.
              if (err + 4'd1 == LOSS_N) begin
                state <= UNLOCKED;
                rxReg <= 1'b0;
                cnt   <= 4'd0;
                err   <= 4'd0;
              end else begin
                err <= err + 4'd1;
              end
            end
          end
          default: begin
            state <= UNLOCKED;
            rxReg <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_comma_aligner.sv
// Directed bench for comma_aligner: table of serial chunks with expected outputs,
// plus hand-written stall and reset-mid-lock sequences.
module tb_comma_aligner;

  typedef struct {
    int          nbits;
    logic [12:0] bits;
    logic        expSym;
    logic        expK;
    logic        expRx;
    logic [9:0]  expData;
    logic [3:0]  expOff;
    int          expStrobes;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   nVec = 0;
  int   nBad = 0;
  int   nStrobe = 0;
  vec_t vecs[15];

  comma_aligner_if bus ();

  comma_aligner #(.LOCK_COUNT(2), .LOSS_COUNT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s[%0d]: got %0h, want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic sendBit(input logic b);
    bus.enb      = 1'b1;
    bus.serialIn = b;
    @(posedge clk);
    #1;
    if (bus.symValid) nStrobe++;
  endtask

  task automatic runVec(input int i);
    nStrobe = 0;
    for (int b = vecs[i].nbits - 1; b >= 0; b--) sendBit(vecs[i].bits[b]);
    check("symValid", i, 32'(bus.symValid), 32'(vecs[i].expSym));
    check("esK285", i, 32'(bus.esK285), 32'(vecs[i].expK));
    check("rxValid", i, 32'(bus.rxValid), 32'(vecs[i].expRx));
    check("dataOut", i, 32'(bus.dataOut), 32'(vecs[i].expData));
    check("offsetCnt", i, 32'(bus.offsetCnt), 32'(vecs[i].expOff));
    check("strobes", i, 32'(nStrobe), 32'(vecs[i].expStrobes));
  endtask

  task automatic setVec(input int i, input int n, input logic [12:0] bits, input logic s,
                        input logic k, input logic rx, input logic [9:0] d,
                        input logic [3:0] off, input int strobes);
    vecs[i].nbits      = n;
    vecs[i].bits       = bits;
    vecs[i].expSym     = s;
    vecs[i].expK       = k;
    vecs[i].expRx      = rx;
    vecs[i].expData    = d;
    vecs[i].expOff     = off;
    vecs[i].expStrobes = strobes;
  endtask

  initial begin
    logic [9:0] sym;
    int t0;

    // Acquisition from reset: junk, K28.5-, K28.5+ (lock at edge 23), then data.
    setVec(0, 3, 13'h0000, 0, 0, 0, 10'h000, 4'd3, 0);
    setVec(1, 10, 13'h00FA, 0, 0, 0, 10'h000, 4'd0, 0);
    setVec(2, 10, 13'h0305, 1, 1, 1, 10'h305, 4'd0, 1);
    setVec(3, 10, 13'h02AA, 1, 0, 1, 10'h2AA, 4'd0, 1);
    setVec(4, 10, 13'h0155, 1, 0, 1, 10'h155, 4'd0, 1);
    // Four commas each slipped by 3 bits; boundaries keep emitting the straddling data.
    setVec(5, 13, 13'h00FA, 0, 0, 1, 10'h01F, 4'd3, 1);
    setVec(6, 13, 13'h00FA, 0, 0, 1, 10'h103, 4'd6, 1);
    setVec(7, 13, 13'h00FA, 0, 0, 1, 10'h3A0, 4'd9, 1);
    setVec(8, 13, 13'h00FA, 0, 0, 0, 10'h03E, 4'd2, 2);
    // Relock with an aligned pair.
    setVec(9, 10, 13'h00FA, 0, 0, 0, 10'h03E, 4'd0, 0);
    setVec(10, 10, 13'h0305, 1, 1, 1, 10'h305, 4'd0, 1);
    // After reset: comma, 4 junk bits, comma (realign), comma -> lock on the third.
    setVec(11, 10, 13'h00FA, 0, 0, 0, 10'h000, 4'd0, 0);
    setVec(12, 4, 13'h0000, 0, 0, 0, 10'h000, 4'd4, 0);
    setVec(13, 10, 13'h00FA, 0, 0, 0, 10'h000, 4'd0, 0);
    setVec(14, 10, 13'h0305, 1, 1, 1, 10'h305, 4'd0, 1);

    bus.enb      = 1'b0;
    bus.serialIn = 1'b0;
    #12;
    check("rstData", 0, 32'(bus.dataOut), 32'h0);
    check("rstSym", 0, 32'(bus.symValid), 32'h0);
    check("rstK", 0, 32'(bus.esK285), 32'h0);
    check("rstRx", 0, 32'(bus.rxValid), 32'h0);
    check("rstOff", 0, 32'(bus.offsetCnt), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i <= 10; i++) runVec(i);

    // Stall across the would-be boundary: 9 bits, 5 disabled clocks, last bit.
    sym = 10'h2AA;
    t0 = cyc;
    nStrobe = 0;
    for (int b = 9; b >= 1; b--) sendBit(sym[b]);
    check("stallPhPre", 0, 32'(bus.offsetCnt), 32'd9);
    bus.enb = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.symValid) nStrobe++;
    end
    check("stallPhHold", 0, 32'(bus.offsetCnt), 32'd9);
    check("stallNoStrobe", 0, 32'(nStrobe), 32'd0);
    sendBit(sym[0]);
    check("stallSym", 0, 32'(bus.symValid), 32'h1);
    check("stallK", 0, 32'(bus.esK285), 32'h0);
    check("stallData", 0, 32'(bus.dataOut), 32'h2AA);
    check("stallGap", 0, 32'(cyc - t0), 32'd15);

    // On-boundary comma while locked is flagged as K28.5.
    sym = 10'h0FA;
    for (int b = 9; b >= 0; b--) sendBit(sym[b]);
    check("lockedKSym", 0, 32'(bus.symValid), 32'h1);
    check("lockedK", 0, 32'(bus.esK285), 32'h1);
    check("lockedKData", 0, 32'(bus.dataOut), 32'h0FA);

    // Asynchronous reset mid-symbol while locked.
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b1);
    check("preRstRx", 0, 32'(bus.rxValid), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("asyncData", 0, 32'(bus.dataOut), 32'h0);
    check("asyncRx", 0, 32'(bus.rxValid), 32'h0);
    check("asyncOff", 0, 32'(bus.offsetCnt), 32'h0);
    check("asyncSym", 0, 32'(bus.symValid), 32'h0);
    @(posedge clk);
    #1;
    check("heldRstOff", 0, 32'(bus.offsetCnt), 32'h0);
    bus.serialIn = 1'b0;
    rst = 1'b1;

    for (int i = 11; i <= 14; i++) runVec(i);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
